vga_layer_mixer: RTL and testbench
==================================

# vga_layer_mixer

Parametrised, pipelined compositor that replaces the single-switch track/camera RGB mux in front of the VGA pins. Takes N layer colour streams aligned to the xvga timing, selects or priority-composites them with a colour key, applies a frame-stepped fade-to-black, and re-emits RGB with hsync/vsync/blank/hcount/vcount delayed to match. Mode, selection and layer enables are shadowed and change only at frame boundaries, so switches never tear a frame.

## Interface
- NUM_LAYERS, 4: number of layer inputs (2..8); layer 0 is lowest priority.
- CHAN_W, 4: bits per colour channel; COLOR_W = 3*CHAN_W, packed R,G,B MSB-first.
- KEY_COLOR, 12'hF0F: transparent colour in OVERLAY mode.
- BG_COLOR, 12'h000: output when no layer wins in OVERLAY.
- FADE_DIV, 2: frames per fade step (≥1).

- clk_in  in  1  pixel clock (65 MHz).
- rst_in  in  1  synchronous, active-low reset.
- hcount_in  in  11  / vcount_in  in  10: xvga counters.
- hsync_in, vsync_in, blank_in  in  1 each: xvga active-high timing.
- layer_rgb_in  in  NUM_LAYERS*COLOR_W: layer i at [i*COLOR_W +: COLOR_W].
- layer_en_in  in  NUM_LAYERS: per-layer enable (OVERLAY only).
- mode_in  in  2: 0 SELECT, 1 OVERLAY, 2 BLACK, 3 reserved (behaves as SELECT).
- sel_in  in  $clog2(NUM_LAYERS): layer for SELECT.
- fade_start_in  in  1: one-cycle pulse, begin fade-out.
- fade_clear_in  in  1: one-cycle pulse, restore full brightness.
- rgb_out  out  COLOR_W: composited colour, 0 while blank.
- hsync_out, vsync_out, blank_out  out  1; hcount_out  out  11; vcount_out  out  10: inputs delayed 2 cycles.
- active_mode_out  out  2: currently applied (shadowed) mode.
- fade_done_out  out  1: high while fade level is 0.

## Operation
- Frame boundary = cycle where vsync_in=1 and its registered previous value=0.
- At a frame boundary, mode_in, sel_in, layer_en_in are copied to shadow registers; only shadow values drive compositing. Mid-frame input changes have no effect until the next boundary.
- sel_in ≥ NUM_LAYERS is latched as-is and selects layer 0.
- SELECT: pixel = layer[sel].
- OVERLAY: pixel = highest-index layer with en=1 and colour ≠ KEY_COLOR; none → BG_COLOR.
- BLACK: pixel = 0.
- Fade FSM, states FULL, FADING, DARK; level 5 bits, 16 = identity, 0 = black.
  - FULL (level 16): fade_start_in → FADING, frame counter cleared.
  - FADING: at each frame boundary, frame counter increments; when it reaches FADE_DIV it clears and level decrements by 1; level reaching 0 → DARK.
  - DARK: level 0; fade_done_out=1.
  - fade_clear_in in any state → FULL, level 16 immediately (next cycle). Same-cycle start and clear: clear wins. fade_start_in in FADING or DARK ignored.
- Scaling per channel: out = (c * level) >> 4, product CHAN_W+5 bits, take bits [CHAN_W+3:4]; level 16 passes c unchanged.
- Blanked pixels output 0 regardless of mode/fade.

## Timing
- Latency 2 cycles, input to rgb_out and all delayed timing outputs; fully pipelined, one pixel per cycle.
- Stage 1: layer select/priority encode, register colour plus timing. Stage 2: fade scale and blank gating, register outputs.
- Shadow registers update the cycle after the boundary; the first pixel using new settings is the first stage-1 pixel after that update (vsync region is blank, so no visible pixel is split).
- Reset (rst_in=0 at clk edge): rgb_out=0, hsync_out=vsync_out=0, blank_out=1, hcount_out=vcount_out=0, active_mode_out=0, shadow sel=0, shadow en=all ones, fade FULL level 16, fade_done_out=0, vsync history=0. Reset mid-fade returns to FULL; a reset mid-frame flushes the pipeline with the reset values above.

## Structure
- Package mixer_pkg: mode enum (MODE_SELECT, MODE_OVERLAY, MODE_BLACK), fade state enum, FADE_FULL=16 constant.
- Sub-module rgb_scale: combinational per-pixel channel multiply by level, parameterised on CHAN_W, instantiated in stage 2.

## Test plan
- Reset, mode_in=0, sel_in=2, layer 2=12'h123 → after first frame boundary, rgb_out=12'h123 two cycles after each unblanked input pixel; hsync/blank delayed exactly 2.
- OVERLAY, en=4'b1111, layers 3..0 = F0F,0A0,F0F,00C → rgb_out=0A0; set layer2=F0F → 00C; all keyed → BG_COLOR 000.
- Change mode_in 0→1 mid-frame (vcount 300) → active_mode_out stays 0 until next boundary, then 1; output switches only then.
- FADE_DIV=2, layer=12'hFFF, fade_start pulse → level 16→15 after 2 boundaries (rgb F→E? (15*15)>>4=14 → 12'hEEE), fade_done_out after 32 boundaries, rgb 000.
- fade_start and fade_clear same cycle while FADING at level 5 → next cycle level 16, state FULL, rgb_out restores 12'hFFF.
- rst_in low for one cycle mid-fade at level 8 → all outputs at reset values, level 16, FULL.

Source files
------------

// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared types and constants for the VGA layer mixer
// Mode and fade-state encodings plus the identity fade level.
package mixer_pkg;

  typedef enum logic [1:0] {
    MODE_SELECT  = 2'd0,
    MODE_OVERLAY = 2'd1,
    MODE_BLACK   = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    FADE_ST_FULL   = 2'd0,
    FADE_ST_FADING = 2'd1,
    FADE_ST_DARK   = 2'd2
  } fade_state_e;

  localparam logic [4:0] FADE_FULL = 5'd16;

endpackage

// File: rtl/vga_layer_mixer_if.sv
// rtl/vga_layer_mixer_if.sv - video stream bundle into and out of the mixer
// Master is the timing/pixel source and sink; slave is the mixer itself.
interface vga_layer_mixer_if #(
  parameter int NUM_LAYERS = 4,
  parameter int CHAN_W     = 4
);
  localparam int COLOR_W = 3 * CHAN_W;

  logic [10:0]                    hcount_in;
  logic [9:0]                     vcount_in;
  logic                           hsync_in;
  logic                           vsync_in;
  logic                           blank_in;
  logic [NUM_LAYERS*COLOR_W-1:0]  layer_rgb_in;

  logic [COLOR_W-1:0]             rgb_out;
  logic [10:0]                    hcount_out;
  logic [9:0]                     vcount_out;
  logic                           hsync_out;
  logic                           vsync_out;
  logic                           blank_out;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, blank_in, layer_rgb_in,
    input  rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, blank_out
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, blank_in, layer_rgb_in,
    output rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, blank_out
  );

endinterface

// File: rtl/rgb_scale.sv
// rtl/rgb_scale.sv - per-channel colour scaling by a 5-bit fade level
// out = (c * level) >> 4, so level 16 passes the colour unchanged.
module rgb_scale #(
  parameter  int CHAN_W  = 4,
  localparam int COLOR_W = 3 * CHAN_W
) (
  input  logic [COLOR_W-1:0] rgb_i,
  input  logic [4:0]         level_i,
  output logic [COLOR_W-1:0] rgb_o
);

  always_comb begin
    rgb_o = '0;
    for (int ch = 0; ch < 3; ch++) begin
      rgb_o[ch*CHAN_W +: CHAN_W] = CHAN_W'(
        ({5'd0, rgb_i[ch*CHAN_W +: CHAN_W]} * {{CHAN_W{1'b0}}, level_i}) >> 4);
    end
  end

endmodule

// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - two-stage layer compositor with frame-stepped fade
// Settings are shadowed at each vsync rising edge so a frame never mixes modes.
module vga_layer_mixer
  import mixer_pkg::*;
#(
  parameter  int                     NUM_LAYERS = 4,
  parameter  int                     CHAN_W     = 4,
  parameter  logic [3*CHAN_W-1:0]    KEY_COLOR  = 12'hF0F,
  parameter  logic [3*CHAN_W-1:0]    BG_COLOR   = 12'h000,
  parameter  int                     FADE_DIV   = 2,
  localparam int                     COLOR_W    = 3 * CHAN_W,
  localparam int                     SEL_W      = $clog2(NUM_LAYERS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  vga_layer_mixer_if.slave      vid,
  input  logic [NUM_LAYERS-1:0] layer_en_in,
  input  logic [1:0]            mode_in,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  fade_start_in,
  input  logic                  fade_clear_in,
  output logic [1:0]            active_mode_out,
  output logic                  fade_done_out
);

  localparam int CNT_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic                  vsync_prev_q;
  logic                  frame_start;
  logic [1:0]            mode_q;
  logic [SEL_W-1:0]      sel_q;
  logic [NUM_LAYERS-1:0] en_q;

  assign frame_start = vid.vsync_in & ~vsync_prev_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      vsync_prev_q <= 1'b0;
      mode_q       <= MODE_SELECT;
      sel_q        <= '0;
      en_q         <= '1;
    end else begin
      vsync_prev_q <= vid.vsync_in;
      if (frame_start) begin
        mode_q <= mode_in;
        sel_q  <= sel_in;
        en_q   <= layer_en_in;
      end
    end
  end

  assign active_mode_out = mode_q;

  // Stage 1: pick the pixel colour from the shadowed settings.
  logic [COLOR_W-1:0] pick;

  always_comb begin
    pick = vid.layer_rgb_in[0 +: COLOR_W];
    case (mode_e'(mode_q))
      MODE_OVERLAY: begin
        pick = BG_COLOR;
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (en_q[i] && (vid.layer_rgb_in[i*COLOR_W +: COLOR_W] != KEY_COLOR)) begin
            pick = vid.layer_rgb_in[i*COLOR_W +: COLOR_W];
          end
        end
      end
      MODE_BLACK: pick = '0;
      default: begin
        // Out-of-range selects fall through to layer 0.
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (SEL_W'(i) == sel_q) pick = vid.layer_rgb_in[i*COLOR_W +: COLOR_W];
        end
      end
    endcase
  end

  logic [COLOR_W-1:0] rgb1_q;
  logic [10:0]        hc1_q;
  logic [9:0]         vc1_q;
  logic               hs1_q, vs1_q, bl1_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rgb1_q <= '0;
      hc1_q  <= '0;
      vc1_q  <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      bl1_q  <= 1'b1;
    end else begin
      rgb1_q <= pick;
      hc1_q  <= vid.hcount_in;
      vc1_q  <= vid.vcount_in;
      hs1_q  <= vid.hsync_in;
      vs1_q  <= vid.vsync_in;
      bl1_q  <= vid.blank_in;
    end
  end

  fade_state_e       fstate_q, fstate_d;
  logic [4:0]        level_q, level_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      fstate_q <= FADE_ST_FULL;
      level_q  <= FADE_FULL;
      fcnt_q   <= '0;
    end else begin
      fstate_q <= fstate_d;
      level_q  <= level_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    fstate_d = fstate_q;
    level_d  = level_q;
    fcnt_d   = fcnt_q;
    if (fade_clear_in) begin
      fstate_d = FADE_ST_FULL;
      level_d  = FADE_FULL;
      fcnt_d   = '0;
    end else begin
      case (fstate_q)
        FADE_ST_FULL: begin
          level_d = FADE_FULL;
          if (fade_start_in) begin
            fstate_d = FADE_ST_FADING;
            fcnt_d   = '0;
          end
        end
        FADE_ST_FADING: begin
          if (frame_start) begin
            if (fcnt_q == CNT_W'(FADE_DIV - 1)) begin
              fcnt_d  = '0;
              level_d = level_q - 5'd1;
              if (level_q == 5'd1) fstate_d = FADE_ST_DARK;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        FADE_ST_DARK: level_d = '0;
        default: begin
          fstate_d = FADE_ST_FULL;
          level_d  = FADE_FULL;
          fcnt_d   = '0;
        end
      endcase
    end
  end

  assign fade_done_out = (level_q == 5'd0);

  // Stage 2: fade scaling, then force black during blanking.
  logic [COLOR_W-1:0] scaled;

  rgb_scale #(.CHAN_W(CHAN_W)) u_scale (
    .rgb_i   (rgb1_q),
    .level_i (level_q),
    .rgb_o   (scaled)
  );

  logic [COLOR_W-1:0] rgb2_q;
  logic [10:0]        hc2_q;
  logic [9:0]         vc2_q;
  logic               hs2_q, vs2_q, bl2_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rgb2_q <= '0;
      hc2_q  <= '0;
      vc2_q  <= '0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      bl2_q  <= 1'b1;
    end else begin
      rgb2_q <= bl1_q ? '0 : scaled;
      hc2_q  <= hc1_q;
      vc2_q  <= vc1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      bl2_q  <= bl1_q;
    end
  end

  assign vid.rgb_out    = rgb2_q;
  assign vid.hcount_out = hc2_q;
  assign vid.vcount_out = vc2_q;
  assign vid.hsync_out  = hs2_q;
  assign vid.vsync_out  = vs2_q;
  assign vid.blank_out  = bl2_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb/tb_vga_layer_mixer.sv - directed checks of selection, overlay, shadowing, fade and reset
module tb_vga_layer_mixer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] en = 4'hF;
  logic [1:0] mode = 2'd0;
  logic [1:0] sel = 2'd0;
  logic       fs = 1'b0;
  logic       fc = 1'b0;
  logic [1:0] amode;
  logic       fdone;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vga_layer_mixer_if #(.NUM_LAYERS(4), .CHAN_W(4)) vif ();

  vga_layer_mixer #(
    .NUM_LAYERS (4),
    .CHAN_W     (4),
    .KEY_COLOR  (12'hF0F),
    .BG_COLOR   (12'h000),
    .FADE_DIV   (2)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rstn),
    .vid             (vif.slave),
    .layer_en_in     (en),
    .mode_in         (mode),
    .sel_in          (sel),
    .fade_start_in   (fs),
    .fade_clear_in   (fc),
    .active_mode_out (amode),
    .fade_done_out   (fdone)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  en;
    logic [47:0] layers;
    logic        blank;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic boundary();
    vif.vsync_in = 1'b1;
    vif.blank_in = 1'b1;
    tick();
    tick();
    vif.vsync_in = 1'b0;
    tick();
  endtask

  task automatic pix_check(input string name, input logic [11:0] exp);
    vif.blank_in = 1'b0;
    tick();
    tick();
    chk(name, {36'd0, vif.rgb_out}, {36'd0, exp});
  endtask

  task automatic pulse_start();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] e_hc [8];
    logic        e_hs [8];
    logic        e_bl [8];

    vif.hcount_in    = '0;
    vif.vcount_in    = '0;
    vif.hsync_in     = 1'b0;
    vif.vsync_in     = 1'b0;
    vif.blank_in     = 1'b0;
    vif.layer_rgb_in = 48'h456_123_789_ABC;
    mode = 2'd1;

    vecs[0]  = '{2'd0, 2'd2, 4'hF, 48'h456_123_789_ABC, 1'b0, 12'h123};
    vecs[1]  = '{2'd0, 2'd0, 4'hF, 48'h456_123_789_ABC, 1'b0, 12'hABC};
    vecs[2]  = '{2'd0, 2'd3, 4'hF, 48'h456_123_789_ABC, 1'b0, 12'h456};
    vecs[3]  = '{2'd1, 2'd0, 4'hF, 48'hF0F_0A0_F0F_00C, 1'b0, 12'h0A0};
    vecs[4]  = '{2'd1, 2'd0, 4'hF, 48'hF0F_F0F_F0F_00C, 1'b0, 12'h00C};
    vecs[5]  = '{2'd1, 2'd0, 4'hF, 48'hF0F_F0F_F0F_F0F, 1'b0, 12'h000};
    vecs[6]  = '{2'd1, 2'd0, 4'hB, 48'hF0F_0A0_333_00C, 1'b0, 12'h333};
    vecs[7]  = '{2'd1, 2'd0, 4'h0, 48'h456_123_789_ABC, 1'b0, 12'h000};
    vecs[8]  = '{2'd2, 2'd1, 4'hF, 48'h456_123_789_ABC, 1'b0, 12'h000};
    vecs[9]  = '{2'd3, 2'd1, 4'hF, 48'h456_123_789_ABC, 1'b0, 12'h789};
    vecs[10] = '{2'd0, 2'd2, 4'hF, 48'h456_123_789_ABC, 1'b1, 12'h000};

    // Reset state, then reset shadow (SELECT, sel 0) without any boundary.
    tick();
    tick();
    chk("rst_rgb", {36'd0, vif.rgb_out}, 48'd0);
    chk("rst_blank", {47'd0, vif.blank_out}, 48'd1);
    chk("rst_hsync", {47'd0, vif.hsync_out}, 48'd0);
    chk("rst_vsync", {47'd0, vif.vsync_out}, 48'd0);
    chk("rst_hcount", {37'd0, vif.hcount_out}, 48'd0);
    chk("rst_vcount", {38'd0, vif.vcount_out}, 48'd0);
    chk("rst_amode", {46'd0, amode}, 48'd0);
    chk("rst_fdone", {47'd0, fdone}, 48'd0);
    rstn = 1'b1;
    pix_check("post_rst_layer0", 12'hABC);

    // Two-cycle alignment of timing signals and colour.
    for (int i = 0; i < 8; i++) begin
      e_hc[i] = 11'(100 + i);
      e_hs[i] = i[1];
      e_bl[i] = (i == 4) || (i == 5);
      vif.hcount_in = e_hc[i];
      vif.vcount_in = 10'(200 + i);
      vif.hsync_in  = e_hs[i];
      vif.blank_in  = e_bl[i];
      tick();
      if (i >= 1) begin
        chk($sformatf("lat_hcount%0d", i), {37'd0, vif.hcount_out}, {37'd0, e_hc[i-1]});
        chk($sformatf("lat_vcount%0d", i), {38'd0, vif.vcount_out}, 48'(200 + i - 1));
        chk($sformatf("lat_hsync%0d", i), {47'd0, vif.hsync_out}, {47'd0, e_hs[i-1]});
        chk($sformatf("lat_blank%0d", i), {47'd0, vif.blank_out}, {47'd0, e_bl[i-1]});
        chk($sformatf("lat_rgb%0d", i), {36'd0, vif.rgb_out},
            e_bl[i-1] ? 48'd0 : 48'hABC);
      end
    end
    vif.hsync_in = 1'b0;

    for (int v = 0; v < 11; v++) begin
      mode = vecs[v].mode;
      sel  = vecs[v].sel;
      en   = vecs[v].en;
      vif.layer_rgb_in = vecs[v].layers;
      boundary();
      vif.blank_in = vecs[v].blank;
      tick();
      tick();
      chk($sformatf("vec%0d_rgb", v), {36'd0, vif.rgb_out}, {36'd0, vecs[v].exp_rgb});
      chk($sformatf("vec%0d_amode", v), {46'd0, amode}, {46'd0, vecs[v].mode});
    end

    // Mid-frame mode change waits for the next boundary.
    mode = 2'd0; sel = 2'd2; en = 4'hF;
    vif.layer_rgb_in = 48'h456_123_789_ABC;
    boundary();
    vif.vcount_in = 10'd300;
    pix_check("mid_before", 12'h123);
    mode = 2'd1;
    pix_check("mid_held", 12'h123);
    chk("mid_amode_held", {46'd0, amode}, 48'd0);
    boundary();
    pix_check("mid_after", 12'h456);
    chk("mid_amode_new", {46'd0, amode}, 48'd1);

    // Fade: one level per two boundaries.
    mode = 2'd0; sel = 2'd0;
    vif.layer_rgb_in = 48'h000_000_000_FFF;
    boundary();
    pix_check("fade_full", 12'hFFF);
    pulse_start();
    for (int k = 1; k <= 22; k++) begin
      boundary();
      if (k == 1) pix_check("fade_k1", 12'hFFF);
      if (k == 2) pix_check("fade_k2", 12'hEEE);
    end
    pix_check("fade_lvl5", 12'h444);
    fs = 1'b1; fc = 1'b1;
    tick();
    fs = 1'b0; fc = 1'b0;
    chk("clear_fdone", {47'd0, fdone}, 48'd0);
    pix_check("clear_rgb", 12'hFFF);
    boundary();
    boundary();
    pix_check("clear_stays_full", 12'hFFF);

    pulse_start();
    for (int k = 1; k <= 31; k++) boundary();
    chk("dark_not_yet", {47'd0, fdone}, 48'd0);
    pix_check("lvl1_rgb", 12'h000);
    boundary();
    chk("dark_fdone", {47'd0, fdone}, 48'd1);
    pix_check("dark_rgb", 12'h000);
    pulse_start();
    chk("dark_ignore_start", {47'd0, fdone}, 48'd1);
    fc = 1'b1;
    tick();
    fc = 1'b0;
    chk("dark_clear", {47'd0, fdone}, 48'd0);
    pix_check("dark_clear_rgb", 12'hFFF);

    // Reset mid-fade at level 8.
    mode = 2'd3;
    boundary();
    pulse_start();
    for (int k = 1; k <= 16; k++) boundary();
    vif.hsync_in = 1'b1;
    vif.hcount_in = 11'd5;
    vif.vcount_in = 10'd7;
    pix_check("lvl8_rgb", 12'h777);
    chk("lvl8_amode", {46'd0, amode}, 48'd3);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mrst_rgb", {36'd0, vif.rgb_out}, 48'd0);
    chk("mrst_blank", {47'd0, vif.blank_out}, 48'd1);
    chk("mrst_hsync", {47'd0, vif.hsync_out}, 48'd0);
    chk("mrst_hcount", {37'd0, vif.hcount_out}, 48'd0);
    chk("mrst_vcount", {38'd0, vif.vcount_out}, 48'd0);
    chk("mrst_amode", {46'd0, amode}, 48'd0);
    chk("mrst_fdone", {47'd0, fdone}, 48'd0);
    pix_check("mrst_full", 12'hFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
